// File: rtl/ram_burst_ctrl_if.sv
// Bundle of command, write-stream, read-stream, RAM and status signals
// for the burst controller. The slave modport is the controller's view;
// the master modport is the view of whatever drives commands, supplies
// write data, consumes read data and models the RAM.
interface ram_burst_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [7:0]  cmd_base;
  logic [7:0]  cmd_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        busy;
  logic        done;

  modport slave (
    input  cmd_valid, cmd_rd, cmd_base, cmd_len,
    input  s_valid, s_data,
    input  m_ready,
    input  ram_dout,
    output cmd_ready, s_ready, m_valid, m_data,
    output ram_addr, ram_we, ram_din,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_rd, cmd_base, cmd_len,
    output s_valid, s_data,
    output m_ready,
    output ram_dout,
    input  cmd_ready, s_ready, m_valid, m_data,
    input  ram_addr, ram_we, ram_din,
    input  busy, done
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a 256x32 synchronous RAM. A command selects a write
// burst (stream words straight into the RAM) or a read burst (issue reads,
// buffer returning data in a 2-entry FIFO and stream it out). The address
// pointer wraps modulo 256. Writes are combinational from the stream handshake;
// reads are throttled so FIFO occupancy plus the read in flight never exceeds 2.
module ram_burst_ctrl (
  input  logic               clk,
  input  logic               rst,
  ram_burst_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;          // RAM address pointer
  logic [7:0]  cnt_q, cnt_d;          // words left to complete, minus 1
  logic [8:0]  iss_q, iss_d;          // read words still to issue
  logic        infl_q, infl_d;        // a read was issued last cycle
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [31:0] m_data_q, m_data_d;    // FIFO head, presented on m_data
  logic [31:0] tail_q, tail_d;        // FIFO second entry
  logic        m_valid_q, m_valid_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        s_ready_q, s_ready_d;

  logic        wr_hs_s;
  logic        pop_s;
  logic [2:0]  occ_s;
  logic        rd_issue_s;

  // s_ready_q is high exactly while in WRITE, so this is the write handshake.
  assign wr_hs_s    = s_ready_q & bus.s_valid;
  assign pop_s      = m_valid_q & bus.m_ready;
  // Occupancy after this cycle's pop; pop implies a non-empty FIFO, so no underflow.
  assign occ_s      = {1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, pop_s};
  assign rd_issue_s = (state_q == ST_READ) && (iss_q != 9'd0) && (occ_s < 3'd2);

  assign bus.ram_we    = wr_hs_s;
  assign bus.ram_addr  = ptr_q;
  assign bus.ram_din   = bus.s_data;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Next-state for the burst FSM, pointer, counters and decoded status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q;
    done_d  = 1'b0;
    infl_d  = rd_issue_s;
    if (wr_hs_s || rd_issue_s) begin
      ptr_d = ptr_q + 8'd1;
    end else begin
      ptr_d = ptr_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          ptr_d   = bus.cmd_base;
          cnt_d   = bus.cmd_len;
          iss_d   = {1'b0, bus.cmd_len} + 9'd1;
          state_d = bus.cmd_rd ? ST_READ : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_hs_s) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_READ: begin
        if (rd_issue_s) begin
          iss_d = iss_q - 9'd1;
        end else begin
          iss_d = iss_q;
        end
        if (pop_s) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    s_ready_d   = (state_d == ST_WRITE);
  end

  // Output FIFO: pop first (shift tail to head), then push returning RAM data.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    m_data_d   = m_data_q;
    tail_d     = tail_q;
    if (pop_s) begin
      m_data_d   = tail_q;
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end else begin
      fifo_cnt_d = fifo_cnt_q;
    end
    if (infl_q) begin
      if (fifo_cnt_d == 2'd0) begin
        m_data_d = bus.ram_dout;
      end else begin
        tail_d = bus.ram_dout;
      end
      fifo_cnt_d = fifo_cnt_d + 2'd1;
    end else begin
      tail_d = tail_d;
    end
    m_valid_d = (fifo_cnt_d != 2'd0);
  end

  // State registers; reset abandons any burst and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 8'd0;
      cnt_q       <= 8'd0;
      iss_q       <= 9'd0;
      infl_q      <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      m_data_q    <= 32'd0;
      tail_q      <= 32'd0;
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      iss_q       <= iss_d;
      infl_q      <= infl_d;
      fifo_cnt_q  <= fifo_cnt_d;
      m_data_q    <= m_data_d;
      tail_q      <= tail_d;
      m_valid_q   <= m_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
    end
  end

endmodule
